// File: rtl/sprite_pkg.sv
// sprite_pkg: shared states, limits and shape ids for the sprite plot sequencer
package sprite_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ERASE, S_DRAW, S_NEXT, S_DONE} state_t;
  localparam int DEF_X_MAX = 159;
  localparam int DEF_Y_MAX = 119;
  localparam int OFS_W = 4;
  localparam logic [1:0] SHAPE_DUCK = 2'd0;
  localparam logic [1:0] SHAPE_HUNTER = 2'd1;
  function automatic state_t first_pass(input logic erase, input logic draw);
    return erase ? S_ERASE : (draw ? S_DRAW : S_NEXT);
  endfunction
endpackage

// File: rtl/sprite_pixel_walker.sv
// sprite_pixel_walker: steps one shape through the offset ROM, one pixel per cycle, clipping off-screen pixels
module sprite_pixel_walker
  import sprite_pkg::*;
#(
  parameter int MAX_PIX = 16,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COL_W = 3,
  parameter int X_MAX = DEF_X_MAX,
  parameter int Y_MAX = DEF_Y_MAX,
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_run,
  input  logic [X_W-1:0]   i_base_x,
  input  logic [Y_W-1:0]   i_base_y,
  input  logic [COL_W-1:0] i_col,
  input  logic [OFS_W-1:0] i_rom_dx,
  input  logic [OFS_W-1:0] i_rom_dy,
  input  logic             i_rom_last,
  output logic [IDX_W-1:0] o_rom_idx,
  output logic             o_plot,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);
  localparam logic [X_W:0] LIM_X = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0] LIM_Y = (Y_W + 1)'(Y_MAX);
  logic [IDX_W-1:0] r_idx;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [COL_W-1:0] r_col;
  logic [X_W:0] w_px;
  logic [Y_W:0] w_py;
  // Negative sums wrap far above the visible limit, so one unsigned compare clips both edges
  assign w_px = {1'b0, i_base_x} + {{(X_W + 1 - OFS_W){i_rom_dx[OFS_W-1]}}, i_rom_dx};
  assign w_py = {1'b0, i_base_y} + {{(Y_W + 1 - OFS_W){i_rom_dy[OFS_W-1]}}, i_rom_dy};
  assign o_last = i_run && (i_rom_last || r_idx == IDX_W'(MAX_PIX - 1));
  assign o_plot = i_run && w_px <= LIM_X && w_py <= LIM_Y;
  assign o_rom_idx = r_idx;
  assign o_x = o_plot ? w_px[X_W-1:0] : r_x;
  assign o_y = o_plot ? w_py[Y_W-1:0] : r_y;
  assign o_col = o_plot ? i_col : r_col;
  // Index advances every walking cycle, clipped or not, and rewinds after the final pixel
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_idx <= '0;
    else r_idx <= (i_run && !o_last) ? r_idx + 1'b1 : '0;
  // Remember the last plotted pixel so the outputs hold steady between plots
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
      r_col <= '0;
    end else if (o_plot) begin
      r_x <= w_px[X_W-1:0];
      r_y <= w_py[Y_W-1:0];
      r_col <= i_col;
    end
endmodule

// File: rtl/sprite_plot_sequencer.sv
// sprite_plot_sequencer: per frame, erases and redraws N sprites on one pixel port; define SPRITE_PLOT_SEQUENCER_ERASE_ALL_EN to erase every sprite before drawing any
module sprite_plot_sequencer
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 7,
  parameter int MAX_PIX = 16,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COL_W = 3,
  parameter int SHP_W = 2,
  parameter int X_MAX = DEF_X_MAX,
  parameter int Y_MAX = DEF_Y_MAX,
  localparam int IDX_W = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [NUM_SPR-1:0]       spr_en,
  input  logic [NUM_SPR*X_W-1:0]   spr_x,
  input  logic [NUM_SPR*Y_W-1:0]   spr_y,
  input  logic [NUM_SPR*COL_W-1:0] spr_col,
  input  logic [NUM_SPR*SHP_W-1:0] spr_shape,
  input  logic [COL_W-1:0]         bg_col,
  output logic [SHP_W-1:0]         rom_shape,
  output logic [IDX_W-1:0]         rom_idx,
  input  logic [OFS_W-1:0]         rom_dx,
  input  logic [OFS_W-1:0]         rom_dy,
  input  logic                     rom_last,
  output logic                     plot,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [COL_W-1:0]         col_out,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               overrun_cnt
);
  localparam int CH_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  state_t r_state, w_nxt, w_first, w_follow, w_wrap, w_post_erase;
  logic [CH_W-1:0] r_ch, w_ch_inc;
  logic w_ch_last, w_run, w_erase, w_last, w_commit;
  logic [NUM_SPR-1:0] r_new_en, r_old_valid;
  logic [NUM_SPR*X_W-1:0] r_new_x, r_old_x;
  logic [NUM_SPR*Y_W-1:0] r_new_y, r_old_y;
  logic [NUM_SPR*SHP_W-1:0] r_new_shape, r_old_shape;
  logic [NUM_SPR*COL_W-1:0] r_new_col;
  logic [7:0] r_overrun;
  logic [X_W-1:0] w_base_x;
  logic [Y_W-1:0] w_base_y;
  logic [COL_W-1:0] w_col;
  assign w_ch_inc = r_ch + 1'b1;
  assign w_ch_last = r_ch == CH_W'(NUM_SPR - 1);
  assign w_erase = r_state == S_ERASE;
`ifdef SPRITE_PLOT_SEQUENCER_ERASE_ALL_EN
  logic r_phase;
  assign w_first = first_pass(r_old_valid[0], 1'b0);
  assign w_follow = r_phase ? first_pass(1'b0, r_new_en[w_ch_inc]) : first_pass(r_old_valid[w_ch_inc], 1'b0);
  assign w_wrap = r_phase ? S_DONE : first_pass(1'b0, r_new_en[0]);
  assign w_post_erase = S_NEXT;
  assign w_commit = r_state == S_NEXT && r_phase;
  // Phase 0 erases every channel, phase 1 draws every channel
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_phase <= 1'b0;
    else if (r_state == S_LOAD) r_phase <= 1'b0;
    else if (r_state == S_NEXT && w_ch_last) r_phase <= 1'b1;
`else
  assign w_first = first_pass(r_old_valid[0], r_new_en[0]);
  assign w_follow = first_pass(r_old_valid[w_ch_inc], r_new_en[w_ch_inc]);
  assign w_wrap = S_DONE;
  assign w_post_erase = r_new_en[r_ch] ? S_DRAW : S_NEXT;
  assign w_commit = r_state == S_NEXT;
`endif
  // State register
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else r_state <= w_nxt;
  // Next-state: walks end on the walker's last flag, NEXT picks the following channel's first pass
  always_comb
    case (r_state)
      S_IDLE:  w_nxt = frame_tick ? S_LOAD : S_IDLE;
      S_LOAD:  w_nxt = w_first;
      S_ERASE: w_nxt = w_last ? w_post_erase : S_ERASE;
      S_DRAW:  w_nxt = w_last ? S_NEXT : S_DRAW;
      S_NEXT:  w_nxt = w_ch_last ? w_wrap : w_follow;
      default: w_nxt = S_IDLE;
    endcase
  // Outputs decoded from state
  always_comb begin
    w_run = r_state == S_ERASE || r_state == S_DRAW;
    busy = r_state == S_LOAD || w_run || r_state == S_NEXT;
    frame_done = r_state == S_DONE;
  end
  // Channel pointer restarts at LOAD and wraps after the last channel
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_ch <= '0;
    else if (r_state == S_LOAD) r_ch <= '0;
    else if (r_state == S_NEXT) r_ch <= w_ch_last ? '0 : w_ch_inc;
  // Snapshot on the accepted tick so later input changes cannot disturb the frame
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_new_en <= '0;
      r_new_x <= '0;
      r_new_y <= '0;
      r_new_col <= '0;
      r_new_shape <= '0;
    end else if (r_state == S_IDLE && frame_tick) begin
      r_new_en <= spr_en;
      r_new_x <= spr_x;
      r_new_y <= spr_y;
      r_new_col <= spr_col;
      r_new_shape <= spr_shape;
    end
  // Commit the drawn image as next frame's erase target
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_old_valid <= '0;
      r_old_x <= '0;
      r_old_y <= '0;
      r_old_shape <= '0;
    end else if (w_commit) begin
      r_old_valid[r_ch] <= r_new_en[r_ch];
      r_old_x[r_ch*X_W +: X_W] <= r_new_x[r_ch*X_W +: X_W];
      r_old_y[r_ch*Y_W +: Y_W] <= r_new_y[r_ch*Y_W +: Y_W];
      r_old_shape[r_ch*SHP_W +: SHP_W] <= r_new_shape[r_ch*SHP_W +: SHP_W];
    end
  // Ticks arriving while a frame is in flight are dropped and counted
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_overrun <= '0;
    else if (frame_tick && r_state != S_IDLE && r_overrun != 8'hFF) r_overrun <= r_overrun + 1'b1;
  assign overrun_cnt = r_overrun;
  assign w_base_x = w_erase ? r_old_x[r_ch*X_W +: X_W] : r_new_x[r_ch*X_W +: X_W];
  assign w_base_y = w_erase ? r_old_y[r_ch*Y_W +: Y_W] : r_new_y[r_ch*Y_W +: Y_W];
  assign w_col = w_erase ? bg_col : r_new_col[r_ch*COL_W +: COL_W];
  assign rom_shape = w_run ? (w_erase ? r_old_shape[r_ch*SHP_W +: SHP_W] : r_new_shape[r_ch*SHP_W +: SHP_W]) : SHP_W'(SHAPE_DUCK);
  sprite_pixel_walker #(
    .MAX_PIX(MAX_PIX),
    .X_W(X_W),
    .Y_W(Y_W),
    .COL_W(COL_W),
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX),
    .IDX_W(IDX_W)
  ) u_walker (
    .clock(clock),
    .reset(reset),
    .i_run(w_run),
    .i_base_x(w_base_x),
    .i_base_y(w_base_y),
    .i_col(w_col),
    .i_rom_dx(rom_dx),
    .i_rom_dy(rom_dy),
    .i_rom_last(rom_last),
    .o_rom_idx(rom_idx),
    .o_plot(plot),
    .o_x(x_out),
    .o_y(y_out),
    .o_col(col_out),
    .o_last(w_last)
  );
endmodule

// File: tb/tb_sprite_plot_sequencer.sv
// tb_sprite_plot_sequencer: randomized frames checked against a pixel-list model of the erase/draw rules
module tb_sprite_plot_sequencer;
  localparam int N = 7, MAXP = 16, XW = 8, YW = 7, CW = 3, SW = 2;
  logic clock = 0, reset = 0, frame_tick = 0;
  logic [N-1:0] spr_en;
  logic [N*XW-1:0] spr_x;
  logic [N*YW-1:0] spr_y;
  logic [N*CW-1:0] spr_col;
  logic [N*SW-1:0] spr_shape;
  logic [CW-1:0] bg_col = 3'd1;
  logic [SW-1:0] rom_shape;
  logic [3:0] rom_idx, rom_dx, rom_dy;
  logic rom_last, plot, busy, frame_done;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] col_out;
  logic [7:0] overrun_cnt;
  int checks = 0, errors = 0, ovr_exp = 0, exp_done;
  int en[N], sx[N], sy[N], scol[N], sshp[N];
  int p_en[N], p_x[N], p_y[N], p_col[N], p_shp[N];
  int m_ov[N], m_ox[N], m_oy[N], m_os[N], drw_start[N];
  int sdx[4][16], sdy[4][16], slen[4];
  logic [63:0] exp_q[$], act_q[$];

  always #5 clock = ~clock;

  always_comb begin
    spr_en = '0;
    spr_x = '0;
    spr_y = '0;
    spr_col = '0;
    spr_shape = '0;
    for (int i = 0; i < N; i++) begin
      spr_en[i] = en[i][0];
      spr_x[i*XW +: XW] = sx[i][XW-1:0];
      spr_y[i*YW +: YW] = sy[i][YW-1:0];
      spr_col[i*CW +: CW] = scol[i][CW-1:0];
      spr_shape[i*SW +: SW] = sshp[i][SW-1:0];
    end
  end

  // Offset ROM; shape 2 never flags its last pixel, so only the length cap ends it
  always_comb begin
    rom_dx = sdx[rom_shape][rom_idx][3:0];
    rom_dy = sdy[rom_shape][rom_idx][3:0];
    rom_last = rom_shape != 2'd2 && int'(rom_idx) == slen[rom_shape] - 1;
  end

  sprite_plot_sequencer dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_col(spr_col), .spr_shape(spr_shape),
    .bg_col(bg_col), .rom_shape(rom_shape), .rom_idx(rom_idx), .rom_dx(rom_dx), .rom_dy(rom_dy),
    .rom_last(rom_last), .plot(plot), .x_out(x_out), .y_out(y_out), .col_out(col_out),
    .busy(busy), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_ev(input int c, input int x, input int y, input int col);
    return {c, x[7:0], y[7:0], col[7:0], 8'h00};
  endfunction

  function automatic int rnd_c(input int lim, input int top);
    int k = $urandom_range(0, 3);
    int hi = (lim + 3 > top) ? top : lim + 3;
    return k == 0 ? $urandom_range(0, 3) : k == 1 ? $urandom_range(lim - 3, hi) : $urandom_range(0, top);
  endfunction

  task automatic rnd_inputs(input int pct);
    for (int i = 0; i < N; i++) begin
      en[i] = ($urandom_range(0, 99) < pct) ? 1 : 0;
      sx[i] = rnd_c(159, 255);
      sy[i] = rnd_c(119, 127);
      scol[i] = $urandom_range(0, 7);
      sshp[i] = $urandom_range(0, 3);
    end
  endtask

  task automatic walk(input int x, input int y, input int s, input int col, inout int c);
    int n = (s == 2) ? MAXP : slen[s];
    for (int i = 0; i < n; i++) begin
      int px = x + sdx[s][i];
      int py = y + sdy[s][i];
      if (px >= 0 && px <= 159 && py >= 0 && py <= 119) exp_q.push_back(mk_ev(c, px, py, col));
      c++;
    end
  endtask

  // Expected pixels with their cycle numbers, counted from the tick-sampling edge
  task automatic build_model();
    int c = 2;
    int bg = int'(bg_col);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      p_en[i] = en[i]; p_x[i] = sx[i]; p_y[i] = sy[i]; p_col[i] = scol[i]; p_shp[i] = sshp[i];
    end
`ifdef SPRITE_PLOT_SEQUENCER_ERASE_ALL_EN
    for (int i = 0; i < N; i++) begin
      if (m_ov[i] != 0) walk(m_ox[i], m_oy[i], m_os[i], bg, c);
      c++;
    end
    for (int i = 0; i < N; i++) begin
      drw_start[i] = c;
      if (p_en[i] != 0) walk(p_x[i], p_y[i], p_shp[i], p_col[i], c);
      c++;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (m_ov[i] != 0) walk(m_ox[i], m_oy[i], m_os[i], bg, c);
      drw_start[i] = c;
      if (p_en[i] != 0) walk(p_x[i], p_y[i], p_shp[i], p_col[i], c);
      c++;
    end
`endif
    exp_done = c;
  endtask

  task automatic run_frame(input int n_ovr, input bit scramble, input int abort_ch);
    int done_cyc = -1;
    int npulse = 0;
    int n;
    build_model();
    act_q.delete();
    @(negedge clock); frame_tick = 1;
    @(negedge clock); frame_tick = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (cyc == 1) begin
        chk("load_busy", busy, 1);
        chk("load_noplot", plot, 0);
      end
      if (abort_ch >= 0 && cyc == drw_start[abort_ch] + 1) begin
        chk("pre_rst_plot", plot, 1);
        frame_tick = 0;
        reset = 0;
        #1;
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun_cnt, 0);
        @(negedge clock); reset = 1;
        for (int i = 0; i < N; i++) m_ov[i] = 0;
        ovr_exp = 0;
        return;
      end
      if (plot) act_q.push_back(mk_ev(cyc, int'(x_out), int'(y_out), int'(col_out)));
      if (frame_done) begin
        done_cyc = cyc;
        chk("done_busy", busy, 0);
        break;
      end
      frame_tick = cyc >= 2 && cyc[0] == 1'b0 && npulse < n_ovr;
      if (frame_tick) begin
        npulse++;
        ovr_exp = (ovr_exp < 255) ? ovr_exp + 1 : 255;
      end
      if (scramble && cyc == 2) rnd_inputs(50);
      @(negedge clock);
    end
    frame_tick = 0;
    if (done_cyc < 0) chk("timeout", 0, 1);
    chk("done_cyc", done_cyc, exp_done);
    chk("npix", act_q.size(), exp_q.size());
    n = (act_q.size() > exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk("pix", (i < act_q.size()) ? act_q[i] : '1, (i < exp_q.size()) ? exp_q[i] : '1);
    @(negedge clock);
    chk("done_pulse", frame_done, 0);
    chk("idle_busy", busy, 0);
    chk("ovr", overrun_cnt, ovr_exp);
    for (int i = 0; i < N; i++) begin
      m_ov[i] = p_en[i]; m_ox[i] = p_x[i]; m_oy[i] = p_y[i]; m_os[i] = p_shp[i];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    slen[0] = 3; slen[1] = 5; slen[2] = 16; slen[3] = 1;
    sdx[0][0] = 0; sdy[0][0] = 0;
    sdx[0][1] = -1; sdy[0][1] = 0;
    sdx[0][2] = 0; sdy[0][2] = 1;
    for (int s = 1; s < 4; s++)
      for (int i = 0; i < 16; i++) begin
        sdx[s][i] = $urandom_range(0, 15) - 8;
        sdy[s][i] = $urandom_range(0, 15) - 8;
      end
    for (int i = 0; i < N; i++) begin
      en[i] = 0; sx[i] = 0; sy[i] = 0; scol[i] = 0; sshp[i] = 0; m_ov[i] = 0;
    end
    repeat (3) @(negedge clock);
    chk("rst_plot0", plot, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", frame_done, 0);
    chk("rst_ovr0", overrun_cnt, 0);
    chk("rst_x0", x_out, 0);
    chk("rst_y0", y_out, 0);
    chk("rst_col0", col_out, 0);
    chk("rst_idx0", rom_idx, 0);
    reset = 1;
    @(negedge clock);
    en[0] = 1; sx[0] = 10; sy[0] = 20; scol[0] = 5; sshp[0] = 0;
    run_frame(0, 0, -1);
    chk("tp1_n", act_q.size(), 3);
`ifndef SPRITE_PLOT_SEQUENCER_ERASE_ALL_EN
    chk("tp1_p0", act_q[0], mk_ev(2, 10, 20, 5));
    chk("tp1_p2", act_q[2], mk_ev(4, 10, 21, 5));
`endif
    sx[0] = 11;
    run_frame(0, 0, -1);
    chk("tp2_n", act_q.size(), 6);
`ifndef SPRITE_PLOT_SEQUENCER_ERASE_ALL_EN
    chk("tp2_erase", act_q[1], mk_ev(3, 9, 20, 1));
    chk("tp2_draw", act_q[3], mk_ev(5, 11, 20, 5));
`endif
    sx[0] = 0; sy[0] = 0;
    run_frame(0, 0, -1);
    chk("clip_n", act_q.size(), 5);
    rnd_inputs(0);
    en[2] = 1; en[5] = 1;
    run_frame(0, 0, -1);
    en[2] = 0;
    run_frame(0, 0, -1);
    run_frame(3, 1, -1);
    chk("ovr3", overrun_cnt, 3);
    repeat (25) begin
      rnd_inputs(60);
      bg_col = $urandom_range(0, 7);
      run_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end
    for (int i = 0; i < N; i++) begin
      en[i] = 1; sshp[i] = 2;
    end
    repeat (3) run_frame(1000, 0, -1);
    chk("ovr_sat", overrun_cnt, 255);
    for (int i = 0; i < N; i++) en[i] = 0;
    en[0] = 1; sx[0] = 50; sy[0] = 50; sshp[0] = 0; scol[0] = 2;
    en[1] = 1; sx[1] = 80; sy[1] = 60; sshp[1] = 0; scol[1] = 6;
    run_frame(0, 0, -1);
    run_frame(0, 0, 1);
    run_frame(0, 0, -1);
    chk("post_rst_n", act_q.size(), 6);
    chk("post_rst_ovr", overrun_cnt, 0);
    sx[1] = 51; sy[1] = 50;
    run_frame(0, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
